// File: rtl/spi_tx_arbiter_if.sv
// Bundle of FIFO-side and serializer-side signals around spi_tx_arbiter.
//   slave  : arbiter view (consumes FIFO status and serializer strobes, drives selects/status)
//   master : environment view (FIFO channels + serializer)
// Signals: ch_empty/ch_full/ch_read_data/ch_read_en (per-channel FIFO ports),
//   ser_empty/ser_full/ser_read_data/ser_read_en/ser_done (serializer side),
//   cs_n (active-low chip selects), grant_id, busy, err_timeout.
interface spi_tx_arbiter_if #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned GW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            ch_empty;
  logic [NUM_CH-1:0]            ch_full;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_read_data;
  logic [NUM_CH-1:0]            ch_read_en;
  logic                         ser_empty;
  logic                         ser_full;
  logic [DATA_WIDTH-1:0]        ser_read_data;
  logic                         ser_read_en;
  logic                         ser_done;
  logic [NUM_CH-1:0]            cs_n;
  logic [GW-1:0]                grant_id;
  logic                         busy;
  logic                         err_timeout;

  modport slave (
    input  ch_empty, ch_full, ch_read_data, ser_read_en, ser_done,
    output ch_read_en, ser_empty, ser_full, ser_read_data, cs_n, grant_id, busy, err_timeout
  );

  modport master (
    output ch_empty, ch_full, ch_read_data, ser_read_en, ser_done,
    input  ch_read_en, ser_empty, ser_full, ser_read_data, cs_n, grant_id, busy, err_timeout
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin scheduler sharing one SPI serializer between NUM_CH transmit FIFOs.
// Grants one channel at a time, drives its chip select, muxes its FIFO read port
// to the serializer and inserts a GUARD_CYCLES chip-select gap between grants.
// Ports: clk, rst (synchronous, active high), bus (spi_tx_arbiter_if.slave).
// Optional build macro SPI_ARB_BURST_EN: up to MAX_BURST words per grant under
// one chip-select window; undefined means exactly one word per grant.
module spi_tx_arbiter #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_BURST      = 4
) (
  input logic             clk,
  input logic             rst,
  spi_tx_arbiter_if.slave bus
);
  localparam int unsigned GW = $clog2(NUM_CH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW = 4;

  // Elaboration-time guard on parameter ranges.
  if (NUM_CH < 2 || NUM_CH > 4 || GUARD_CYCLES < 1 || GUARD_CYCLES > 15 ||
      TIMEOUT_CYCLES < 1 || MAX_BURST < 1) begin : g_bad_param
    $error("spi_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_XFER, ARB_GUARD} arb_state_e;

  arb_state_e          state;
  logic [GW-1:0]       grant_q;
  logic [CW-1:0]       guard_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic                err_q;
`ifdef SPI_ARB_BURST_EN
  localparam int unsigned BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  logic [BW-1:0]       burst_cnt;
`endif

  logic [GW-1:0]         pick;
  logic [GW-1:0]         cand;
  logic                  any_req;
  logic                  sel_empty;
  logic                  sel_full;
  logic [DATA_WIDTH-1:0] sel_data;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    pick    = grant_q;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = GW'((32'(grant_q) + i) % NUM_CH);
      if (!any_req && !bus.ch_empty[cand]) begin
        pick    = cand;
        any_req = 1'b1;
      end
    end
  end

  // Mux of the granted channel's FIFO port.
  always_comb begin
    sel_empty = 1'b1;
    sel_full  = 1'b0;
    sel_data  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_q == GW'(c)) begin
        sel_empty = bus.ch_empty[c];
        sel_full  = bus.ch_full[c];
        sel_data  = bus.ch_read_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbiter state machine, guard/timeout counters and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant_q   <= GW'(NUM_CH - 1);
      guard_cnt <= '0;
      tmo_cnt   <= '0;
      err_q     <= 1'b0;
`ifdef SPI_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_q <= pick;
            state   <= ARB_SETUP;
          end
        end
        ARB_SETUP: begin
          tmo_cnt <= '0;
`ifdef SPI_ARB_BURST_EN
          burst_cnt <= '0;
`endif
          state   <= ARB_XFER;
        end
        ARB_XFER: begin
          if (bus.ser_done) begin
`ifdef SPI_ARB_BURST_EN
            if ((32'(burst_cnt) < MAX_BURST - 1) && !sel_empty) begin
              burst_cnt <= burst_cnt + BW'(1);
              tmo_cnt   <= '0;
            end else begin
              guard_cnt <= '0;
              state     <= ARB_GUARD;
            end
`else
            guard_cnt <= '0;
            state     <= ARB_GUARD;
`endif
          end else begin
            // Saturating count; the FSM keeps waiting for done after the flag sets.
            if (tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) err_q <= 1'b1;
          end
        end
        ARB_GUARD: begin
          if (guard_cnt == CW'(GUARD_CYCLES - 1)) state <= ARB_IDLE;
          else guard_cnt <= guard_cnt + CW'(1);
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  logic [NUM_CH-1:0]     cs_n_d;
  logic [NUM_CH-1:0]     rd_en_d;
  logic                  ser_empty_d;
  logic                  ser_full_d;
  logic [DATA_WIDTH-1:0] ser_data_d;

  // Output decode from registered state and grant; read strobe is a pass-through.
  always_comb begin
    cs_n_d      = '1;
    rd_en_d     = '0;
    ser_empty_d = 1'b1;
    ser_full_d  = 1'b0;
    ser_data_d  = '0;
    if (state == ARB_SETUP || state == ARB_XFER) cs_n_d[grant_q] = 1'b0;
    if (state == ARB_XFER) begin
      ser_empty_d      = sel_empty;
      ser_full_d       = sel_full;
      ser_data_d       = sel_data;
      rd_en_d[grant_q] = bus.ser_read_en;
    end
  end

  assign bus.cs_n          = cs_n_d;
  assign bus.ch_read_en    = rd_en_d;
  assign bus.ser_empty     = ser_empty_d;
  assign bus.ser_full      = ser_full_d;
  assign bus.ser_read_data = ser_data_d;
  assign bus.grant_id      = grant_q;
  assign bus.busy          = (state != ARB_IDLE);
  assign bus.err_timeout   = err_q;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: two FIFO channels modelled as push/pop
// counters with word value 8'hA5 + 16*channel + word_index; the bench plays
// the serializer by pulsing ser_read_en and ser_done.
module tb_spi_tx_arbiter;
  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 8;

  logic clk = 1'b0;
  logic rst;
  logic s_rd;
  logic s_done;
  logic [NCH-1:0] full_q;
  int pushed [NCH];
  int popped [NCH];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_tx_arbiter_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

  spi_tx_arbiter #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .GUARD_CYCLES(2), .TIMEOUT_CYCLES(64), .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.ser_read_en = s_rd;
  assign bus.ser_done    = s_done;
  assign bus.ch_full     = full_q;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      bus.ch_empty[c] = (pushed[c] == popped[c]);
      bus.ch_read_data[c*DW +: DW] = 8'(32'hA5 + 32'(16 * c) + 32'(popped[c]));
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst) popped[c] <= 0;
      else if (bus.ch_read_en[c]) popped[c] <= popped[c] + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    s_rd = 1'b0;
    s_done = 1'b0;
    full_q = '0;
    pushed = '{0, 0};
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_xfer(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.ser_empty) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Serializer stand-in: take one word, finish, and observe the guard gap.
  task automatic ser_xfer(output int ch, output logic [7:0] d, output int gap_hi, output bit ok);
    wait_xfer(ok);
    ch = int'(bus.grant_id);
    d = bus.ser_read_data;
    gap_hi = 0;
    if (ok) begin
      s_rd = 1'b1;
      tick();
      s_rd = 1'b0;
      tick();
      tick();
      s_done = 1'b1;
      tick();
      s_done = 1'b0;
      for (int g = 0; g < 2; g++) begin
        if (bus.cs_n == 2'b11) gap_hi++;
        tick();
      end
    end
  endtask

  task automatic test_reset;
    logic [16:0] obs, exp_v;
    bit ok;
    exp_v = {2'b11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00};
    do_reset();
    obs = {bus.cs_n, bus.ser_empty, bus.ser_full, bus.ser_read_data, bus.busy,
           bus.grant_id, bus.err_timeout, bus.ch_read_en};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", obs, exp_v);
    end
    for (int ch = 1; ch >= 0; ch--) begin
      do_reset();
      pushed[ch] = 1;
      wait_xfer(ok);
      checks++;
      if (!ok || bus.grant_id !== 1'(ch)) begin
        failures++;
        $display("FAIL reset_pre_grant ch=%0d ok=%0d grant=%0d want=%0d", ch, ok, bus.grant_id, ch);
      end
      rst = 1'b1;
      s_rd = 1'b1;
      tick();
      obs = {bus.cs_n, bus.ser_empty, bus.ser_full, bus.ser_read_data, bus.busy,
             bus.grant_id, bus.err_timeout, bus.ch_read_en};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_mid_xfer ch=%0d got=%h want=%h", ch, obs, exp_v);
      end
      rst = 1'b0;
      s_rd = 1'b0;
    end
  endtask

  task automatic test_single;
    do_reset();
    full_q = 2'b11;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.ser_full !== 1'b0 || bus.cs_n !== 2'b11) begin
      failures++;
      $display("FAIL full_no_request busy=%b ser_full=%b cs_n=%b want 0 0 11", bus.busy, bus.ser_full, bus.cs_n);
    end
    pushed[0] = 1;
    tick();
    checks++;
    if (bus.cs_n !== 2'b10 || bus.ser_empty !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL setup_cycle cs_n=%b ser_empty=%b busy=%b want 10 1 1", bus.cs_n, bus.ser_empty, bus.busy);
    end
    tick();
    checks++;
    if (bus.cs_n !== 2'b10 || bus.ser_empty !== 1'b0 || bus.ser_read_data !== 8'hA5 || bus.ser_full !== 1'b1) begin
      failures++;
      $display("FAIL xfer_present cs_n=%b empty=%b data=%h full=%b want 10 0 a5 1",
               bus.cs_n, bus.ser_empty, bus.ser_read_data, bus.ser_full);
    end
    s_rd = 1'b1;
    #1;
    checks++;
    if (bus.ch_read_en !== 2'b01) begin
      failures++;
      $display("FAIL read_en_route got=%b want=01", bus.ch_read_en);
    end
    tick();
    s_rd = 1'b0;
    #1;
    checks++;
    if (bus.ch_read_en !== 2'b00 || bus.ser_empty !== 1'b1 || popped[0] !== 1) begin
      failures++;
      $display("FAIL drain_once rd_en=%b empty=%b pops=%0d want 00 1 1", bus.ch_read_en, bus.ser_empty, popped[0]);
    end
    tick();
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (bus.cs_n !== 2'b11 || bus.busy !== 1'b1 || bus.ser_empty !== 1'b1 || bus.ser_full !== 1'b0) begin
        failures++;
        $display("FAIL guard_cycle%0d cs_n=%b busy=%b empty=%b full=%b want 11 1 1 0",
                 g, bus.cs_n, bus.busy, bus.ser_empty, bus.ser_full);
      end
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.cs_n !== 2'b11 || bus.grant_id !== 1'b0) begin
      failures++;
      $display("FAIL back_to_idle busy=%b cs_n=%b grant=%0d want 0 11 0", bus.busy, bus.cs_n, bus.grant_id);
    end
    full_q = '0;
  endtask

  task automatic test_round_robin;
    int ch, gap, exp_ch;
    logic [7:0] d, exp_d;
    bit ok;
    do_reset();
    pushed = '{3, 3};
    for (int i = 0; i < 6; i++) begin
      ser_xfer(ch, d, gap, ok);
      exp_ch = i % 2;
      exp_d = 8'(32'hA5 + 32'(16 * exp_ch) + 32'(i / 2));
      checks++;
      if (!ok || ch !== exp_ch || d !== exp_d || gap !== 2) begin
        failures++;
        $display("FAIL rr_grant%0d ok=%0d ch=%0d data=%h gap=%0d want ch=%0d data=%h gap=2",
                 i, ok, ch, d, gap, exp_ch, exp_d);
      end
    end
  endtask

  task automatic test_late_request;
    int ch, gap;
    logic [7:0] d;
    bit ok;
    do_reset();
    pushed[0] = 1;
    wait_xfer(ok);
    pushed[1] = 1;
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    tick();
    checks++;
    if (!ok || bus.grant_id !== 1'b0 || bus.cs_n !== 2'b10) begin
      failures++;
      $display("FAIL late_no_switch ok=%0d grant=%0d cs_n=%b want grant=0 cs_n=10", ok, bus.grant_id, bus.cs_n);
    end
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    checks++;
    if (bus.cs_n !== 2'b11) begin
      failures++;
      $display("FAIL late_guard cs_n=%b want=11", bus.cs_n);
    end
    ser_xfer(ch, d, gap, ok);
    checks++;
    if (!ok || ch !== 1 || d !== 8'hB5) begin
      failures++;
      $display("FAIL late_grant ok=%0d ch=%0d data=%h want ch=1 data=b5", ok, ch, d);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    do_reset();
    pushed[0] = 1;
    wait_xfer(ok);
    repeat (63) tick();
    checks++;
    if (!ok || bus.err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early ok=%0d err=%b want 0", ok, bus.err_timeout);
    end
    tick();
    checks++;
    if (bus.err_timeout !== 1'b1 || bus.cs_n !== 2'b10) begin
      failures++;
      $display("FAIL timeout_set err=%b cs_n=%b want 1 10", bus.err_timeout, bus.cs_n);
    end
    repeat (10) tick();
    checks++;
    if (bus.err_timeout !== 1'b1 || bus.cs_n !== 2'b10 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky err=%b cs_n=%b busy=%b want 1 10 1", bus.err_timeout, bus.cs_n, bus.busy);
    end
    do_reset();
    checks++;
    if (bus.err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear err=%b want 0", bus.err_timeout);
    end
  endtask

`ifdef SPI_ARB_BURST_EN
  task automatic test_burst;
    bit ok;
    logic [1:0] exp_cs;
    logic [7:0] exp_d;
    do_reset();
    pushed[0] = 6;
    for (int w = 0; w < 6; w++) begin
      wait_xfer(ok);
      exp_d = 8'(32'hA5 + 32'(w));
      checks++;
      if (!ok || bus.ser_read_data !== exp_d || bus.cs_n !== 2'b10) begin
        failures++;
        $display("FAIL burst_word%0d ok=%0d data=%h cs_n=%b want %h 10", w, ok, bus.ser_read_data, bus.cs_n, exp_d);
      end
      s_rd = 1'b1;
      tick();
      s_rd = 1'b0;
      tick();
      s_done = 1'b1;
      tick();
      s_done = 1'b0;
      exp_cs = (w == 3 || w == 5) ? 2'b11 : 2'b10;
      checks++;
      if (bus.cs_n !== exp_cs) begin
        failures++;
        $display("FAIL burst_cs%0d cs_n=%b want=%b", w, bus.cs_n, exp_cs);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    s_rd = 1'b0;
    s_done = 1'b0;
    full_q = '0;
    pushed = '{0, 0};
    test_reset();
    test_single();
`ifndef SPI_ARB_BURST_EN
    test_round_robin();
`else
    test_burst();
`endif
    test_late_request();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
